// File: rtl/vector_pkg.sv
// Shared vector-unit types and sizes.
// The vector register file, the decoder and the vector ALU all import this package.
package vector_pkg;

  localparam int VLEN   = 128;
  localparam int VREGS  = 16;
  localparam int VRAW   = 4;
  localparam int VWORDS = VLEN / 32;

  typedef logic [VLEN-1:0] vreg_t;
  typedef logic [VRAW-1:0] vaddr_t;
  typedef logic [VWORDS-1:0] vmask_t;

  typedef enum logic [3:0] {
    VALU_ADD  = 4'd0,
    VALU_SUB  = 4'd1,
    VALU_AND  = 4'd2,
    VALU_OR   = 4'd3,
    VALU_XOR  = 4'd4,
    VALU_SLL  = 4'd5,
    VALU_SRL  = 4'd6,
    VALU_ROT  = 4'd7,
    VALU_AESE = 4'd8,
    VALU_AESD = 4'd9,
    VALU_MOV  = 4'd10
  } valu_op_t;

  // Word i of a vector covers bits [32i+31:32i].
  function automatic logic [31:0] vword(input vreg_t v, input int unsigned i);
    return v[32*i +: 32];
  endfunction

endpackage

// File: rtl/vector_regfile_if.sv
// Read/write port bundle between the vector pipeline and the vector register file.
// The master (pipeline) drives addresses and write data; the slave (register file) returns read data.
interface vector_regfile_if #(
  parameter int WIDTH = 128,
  parameter int AW    = 4
);
  logic [AW-1:0]       ra1;
  logic [AW-1:0]       ra2;
  logic [WIDTH-1:0]    rd1;
  logic [WIDTH-1:0]    rd2;
  logic                we;
  logic [AW-1:0]       wa;
  logic [WIDTH/32-1:0] wmask;
  logic [WIDTH-1:0]    wd;
  logic                wr_busy;

  modport master (
    output ra1, ra2, we, wa, wmask, wd,
    input  rd1, rd2, wr_busy
  );

  modport slave (
    input  ra1, ra2, we, wa, wmask, wd,
    output rd1, rd2, wr_busy
  );
endinterface

// File: rtl/vreg_bypass_mux.sv
// One read port: merges stored register data with same-cycle write data, word by word.
// Address 0 and reset both force the port to zero.
module vreg_bypass_mux #(
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic                rst_n,
  input  logic [AW-1:0]       raddr,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WIDTH/32-1:0] wmask,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [WIDTH-1:0]    stored,
  output logic [WIDTH-1:0]    rdata
);

  localparam int NW = WIDTH / 32;

  logic hit;

  always_comb begin
    // A write presented during reset never reaches the read ports.
    hit   = rst_n && we && (waddr == raddr) && (raddr != '0);
    rdata = '0;
    if (rst_n && (raddr != '0)) begin
      for (int i = 0; i < NW; i++) begin
        rdata[32*i +: 32] = (hit && wmask[i]) ? wdata[32*i +: 32] : stored[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/vector_regfile.sv
// Vector register file: 2 combinational read ports with write-through bypass,
// 1 synchronous word-masked write port, v0 hardwired to zero.
module vector_regfile
  import vector_pkg::*;
#(
  parameter int WIDTH = VLEN,
  parameter int NREGS = VREGS,
  parameter int AW    = VRAW
) (
  input logic             clk,
  input logic             rst_n,
  vector_regfile_if.slave bus
);

  localparam int NW = WIDTH / 32;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wr_busy_q;
  logic             wr_busy_d;
  logic             wr_valid;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  always_comb begin
    // An all-zero mask or a write to v0 changes nothing and must not stall the pipe.
    wr_valid  = bus.we && (bus.wa != '0) && (|bus.wmask);
    wr_busy_d = wr_valid;
    regs_d    = regs_q;
    if (wr_valid) begin
      for (int i = 0; i < NW; i++) begin
        if (bus.wmask[i]) begin
          regs_d[bus.wa][32*i +: 32] = bus.wd[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      wr_busy_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wr_busy_q <= wr_busy_d;
    end
  end

  assign stored1     = regs_q[bus.ra1];
  assign stored2     = regs_q[bus.ra2];
  assign bus.wr_busy = wr_busy_q;

  vreg_bypass_mux #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_byp1 (
    .rst_n  (rst_n),
    .raddr  (bus.ra1),
    .we     (bus.we),
    .waddr  (bus.wa),
    .wmask  (bus.wmask),
    .wdata  (bus.wd),
    .stored (stored1),
    .rdata  (bus.rd1)
  );

  vreg_bypass_mux #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_byp2 (
    .rst_n  (rst_n),
    .raddr  (bus.ra2),
    .we     (bus.we),
    .waddr  (bus.wa),
    .wmask  (bus.wmask),
    .wdata  (bus.wd),
    .stored (stored2),
    .rdata  (bus.rd2)
  );

endmodule

// File: tb/tb_vector_regfile.sv
// Directed bench for vector_regfile: table of per-cycle vectors with hand-computed
// read data and wr_busy, followed by a hand-written asynchronous reset sequence.
module tb_vector_regfile;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vector_regfile_if #(.WIDTH(128), .AW(4)) vif ();

  vector_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic         we;
    logic [3:0]   wa;
    logic [3:0]   wmask;
    logic [127:0] wd;
    logic [127:0] e_rd1;
    logic [127:0] e_rd2;
    logic         e_busy;
  } vec_t;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] VA   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] VB   = 128'h00112233_DEADBEEF_8899AABB_CCDDEEFF;
  localparam logic [127:0] V6   = 128'h600DF00D_00000000_00000000_00000000;
  localparam logic [127:0] V7A  = 128'h00000000_00000000_00000000_01234567;
  localparam logic [127:0] V7B  = 128'h00000000_00000000_89ABCDEF_01234567;
  localparam logic [127:0] V9A  = 128'h00000000_00000000_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] V9B  = 128'h00000000_55555555_55555555_AAAAAAAA;
  localparam logic [127:0] W15  = 128'hCAFEBABE_0BADF00D_13579BDF_2468ACE0;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [3:0] ra1, input logic [3:0] ra2, input logic we,
                              input logic [3:0] wa, input logic [3:0] wmask, input logic [127:0] wd,
                              input logic [127:0] e1, input logic [127:0] e2, input logic eb);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.we = we; v.wa = wa; v.wmask = wmask; v.wd = wd;
    v.e_rd1 = e1; v.e_rd2 = e2; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic we,
                       input logic [3:0] wa, input logic [3:0] wmask, input logic [127:0] wd);
    vif.ra1 = ra1; vif.ra2 = ra2; vif.we = we; vif.wa = wa; vif.wmask = wmask; vif.wd = wd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 4'd0, 4'h0, '0);

    //           ra1    ra2    we    wa     mask     wd                                      rd1   rd2   busy
    tbl[0]  = mk(4'd0,  4'd0,  1'b0, 4'd0,  4'h0,    '0,                                     '0,   '0,   1'b0);
    tbl[1]  = mk(4'd5,  4'd1,  1'b1, 4'd5,  4'hF,    VA,                                     VA,   '0,   1'b1);
    tbl[2]  = mk(4'd5,  4'd5,  1'b0, 4'd0,  4'h0,    '0,                                     VA,   VA,   1'b0);
    tbl[3]  = mk(4'd5,  4'd0,  1'b1, 4'd5,  4'b0100, 128'h00000000_DEADBEEF_00000000_00000000, VB, '0,   1'b1);
    tbl[4]  = mk(4'd5,  4'd6,  1'b0, 4'd0,  4'h0,    '0,                                     VB,   '0,   1'b0);
    tbl[5]  = mk(4'd6,  4'd5,  1'b1, 4'd6,  4'b1000, 128'h600DF00D_FFFFFFFF_FFFFFFFF_FFFFFFFF, V6, VB,   1'b1);
    tbl[6]  = mk(4'd7,  4'd7,  1'b1, 4'd7,  4'b0001, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_01234567, V7A, V7A, 1'b1);
    tbl[7]  = mk(4'd7,  4'd6,  1'b1, 4'd7,  4'h0,    ONES,                                   V7A,  V6,   1'b0);
    tbl[8]  = mk(4'd0,  4'd0,  1'b1, 4'd0,  4'hF,    ONES,                                   '0,   '0,   1'b0);
    tbl[9]  = mk(4'd0,  4'd7,  1'b0, 4'd0,  4'h0,    '0,                                     '0,   V7A,  1'b0);
    tbl[10] = mk(4'd9,  4'd3,  1'b1, 4'd9,  4'b0011, {16{8'hAA}},                            V9A,  '0,   1'b1);
    tbl[11] = mk(4'd9,  4'd9,  1'b1, 4'd9,  4'b0110, {16{8'h55}},                            V9B,  V9B,  1'b1);
    tbl[12] = mk(4'd9,  4'd5,  1'b0, 4'd0,  4'h0,    '0,                                     V9B,  VB,   1'b0);
    tbl[13] = mk(4'd6,  4'd7,  1'b1, 4'd7,  4'b0010, 128'hFFFFFFFF_FFFFFFFF_89ABCDEF_FFFFFFFF, V6, V7B,  1'b1);
    tbl[14] = mk(4'd7,  4'd15, 1'b0, 4'd0,  4'h0,    '0,                                     V7B,  '0,   1'b0);
    tbl[15] = mk(4'd15, 4'd14, 1'b1, 4'd15, 4'hF,    W15,                                    W15,  '0,   1'b1);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd1", vif.rd1, '0);
    chk("reset_busy", {127'd0, vif.wr_busy}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].we, tbl[i].wa, tbl[i].wmask, tbl[i].wd);
      #1;
      chk($sformatf("vec%0d_rd1", i), vif.rd1, tbl[i].e_rd1);
      chk($sformatf("vec%0d_rd2", i), vif.rd2, tbl[i].e_rd2);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), {127'd0, vif.wr_busy}, {127'd0, tbl[i].e_busy});
    end

    // Write v3 to all ones, then pull reset mid-cycle: reads must clear with no clock edge.
    @(negedge clk);
    drive(4'd3, 4'd9, 1'b1, 4'd3, 4'hF, ONES);
    @(posedge clk);
    #1;
    drive(4'd3, 4'd9, 1'b0, 4'd0, 4'h0, '0);
    #1;
    chk("v3_written", vif.rd1, ONES);
    chk("v3_busy", {127'd0, vif.wr_busy}, 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd1", vif.rd1, '0);
    chk("async_rst_rd2", vif.rd2, '0);
    chk("async_rst_busy", {127'd0, vif.wr_busy}, 128'd0);

    // A write held through a clock edge in reset is neither bypassed nor stored.
    drive(4'd3, 4'd3, 1'b1, 4'd3, 4'hF, ONES);
    #1;
    chk("rst_no_bypass", vif.rd1, '0);
    @(posedge clk);
    #1;
    chk("rst_edge_busy", {127'd0, vif.wr_busy}, 128'd0);

    // First edge after release accepts a write; the write seen in reset left v3 at 0.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 4'd3, 1'b1, 4'd4, 4'hF, W15);
    @(posedge clk);
    #1;
    drive(4'd4, 4'd3, 1'b0, 4'd0, 4'h0, '0);
    #1;
    chk("post_rst_v4", vif.rd1, W15);
    chk("post_rst_v3", vif.rd2, '0);
    chk("post_rst_busy", {127'd0, vif.wr_busy}, 128'd1);
    @(posedge clk);
    #1;
    chk("post_rst_busy_clr", {127'd0, vif.wr_busy}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_regfile.md
Name: vector_regfile

Overview:
- Vector register file that feeds the 128-bit vector ALU: two combinational read ports drive op1/op2, and one synchronous write port takes writeback results.
- 16 architectural vector registers of 128 bits each. v0 is hardwired to zero.
- Per-32-bit-word write enables, so the AES key-schedule flow can insert single words without a read-modify-write.
- Write-through bypass, so a same-cycle read of a register being written returns the new data.

Parameters:
- WIDTH, 128, vector register width in bits; must be a multiple of 32.
- NREGS, 16, number of vector registers; must be a power of 2.
- AW, 4, address width; must equal log2(NREGS).

Ports:
- clk  input  1  core clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  AW  read address, port 1 (drives ALU op1).
- ra2  input  AW  read address, port 2 (drives ALU op2).
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- we  input  1  write strobe.
- wa  input  AW  write address.
- wmask  input  WIDTH/32  per-32-bit-word write enable; bit i covers bits [32i+31:32i].
- wd  input  WIDTH  write data.
- wr_busy  output  1  high for the single cycle after any accepted write; used by hazard/stall logic.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All registers clear to 0; wr_busy=0.
  - rd1/rd2 read 0 for every address while in reset.
  - Any write presented during reset is discarded.
- Reset release: the first write can be accepted on the first rising clk edge with rst_n=1.
- Write:
  - On posedge clk, if we=1 and wa!=0, each word i with wmask[i]=1 is written with wd word i.
  - Words with wmask[i]=0 are unchanged.
  - we=1 with wmask=0 is a no-op and does not set wr_busy.
- v0:
  - Writes to wa=0 are ignored and do not set wr_busy.
  - Reads of address 0 always return 0, including through the bypass.
- Read: combinational, zero latency.
  - rdN = bypass_word when the bypass condition holds, else reg[raN].
  - Bypass condition: we=1, wa==raN, raN!=0. Under this condition each word i returns wd word i if wmask[i]=1, otherwise the stored word i.
- Both ports may address the same register; both see identical data, including bypass.
- wr_busy: registered. Set to 1 on an edge where a valid write occurs (we=1, wa!=0, wmask!=0), otherwise cleared to 0.
- Back-to-back writes to the same address on consecutive cycles: the second applies on top of the first, masks compose word-wise, and the last write wins per word.
- No X propagation: an out-of-range address is impossible by construction (AW=log2 NREGS).

Decomposition:
- Shared package vector_pkg:
  - VLEN=128, VREGS=16, VRAW=4, VWORDS=VLEN/32.
  - typedef vreg_t (logic [VLEN-1:0]) and vaddr_t.
  - The valu_op enum moves here so decoder and ALU share it.
- One sub-module, vreg_bypass_mux: per-port word-wise merge of stored data and write data. It is instantiated twice.

Test Plan:
- Reset: pulse rst_n low asynchronously mid-cycle after writing v3=0xFFFF..FF -> rd1 with ra1=3 reads 0 immediately, without waiting for a clock edge; wr_busy=0.
- Full write then read: we=1, wa=5, wmask=4'hF, wd=0x00112233_44556677_8899AABB_CCDDEEFF; next cycle ra1=5 -> rd1 equals wd; wr_busy=1 for exactly one cycle.
- Masked write: v5 holds the value above; write wmask=4'b0100, wd=0xDEADBEEF in word 2 -> v5=0x00112233_DEADBEEF_8899AABB_CCDDEEFF.
- Bypass:
  - Same cycle as we=1, wa=7, wmask=4'b0001, wd word0=0x01234567, with v7=0 and ra1=ra2=7 -> both rd1 and rd2 show 0x00000000_00000000_00000000_01234567 combinationally.
  - ra1=6 in the same cycle -> rd1 shows the stored v6.
- v0: we=1, wa=0, wmask=4'hF, wd=all ones -> rd1 with ra1=0 reads 0 in the same cycle and the next; wr_busy stays 0.
- Consecutive writes to v9: first wmask=4'b0011, wd all 0xAA bytes; second wmask=4'b0110, wd all 0x55 bytes -> v9 = words {0, 0x55555555, 0x55555555, 0xAAAAAAAA} (words 3..0); wr_busy high for 2 cycles.
